// File: rtl/mem_handshake_ram.sv
// mem_handshake_ram
//
// Byte-addressed, big-endian data memory behind an MFA/MFC handshake.
// A request is captured in IDLE when MFA is high. The block waits LATENCY
// cycles in BUSY and performs one byte, halfword or word access using only
// the captured values. It then raises MFC in DONE until MFA is seen low.
//
// Ports:
//   CLK      - system clock, rising edge
//   Reset    - asynchronous, active-low reset
//   MFA      - memory function activate (level request)
//   RW       - 1 = write, 0 = read
//   Size     - 00 byte, 01 halfword, 10 word, 11 treated as word
//   Address  - byte address (aligned down to the access size on capture)
//   DataIn   - right-justified write data
//   DataOut  - right-justified, zero-extended read data (held between reads)
//   MFC      - memory function complete
//   Busy     - high in BUSY and DONE
module mem_handshake_ram #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dout_q, dout_d;

    // Storage is never reset; contents survive Reset.
    logic [7:0]        mem [DEPTH];

    logic              access;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] addr1, addr2, addr3;

    // Force the address down to the access size so no access can cross
    // the top of memory.
    function automatic logic [ADDR_W-1:0] align_addr(
        input logic [ADDR_W-1:0] a,
        input logic [1:0]        sz
    );
        logic [ADDR_W-1:0] r;
        r = a;
        if (sz == 2'b01) begin
            r[0] = 1'b0;
        end else if (sz[1]) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    assign addr1 = addr_q + ADDR_W'(1);
    assign addr2 = addr_q + ADDR_W'(2);
    assign addr3 = addr_q + ADDR_W'(3);

    // Big-endian assembly: lowest address holds the most significant byte.
    always_comb begin
        rdata = 32'h0;
        case (size_q)
            2'b00:   rdata[7:0]  = mem[addr_q];
            2'b01:   rdata[15:0] = {mem[addr_q], mem[addr1]};
            default: rdata       = {mem[addr_q], mem[addr1], mem[addr2], mem[addr3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        access  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MFA) begin
                    rw_d    = RW;
                    size_d  = Size;
                    addr_d  = align_addr(Address, Size);
                    wdata_d = DataIn;
                    count_d = 4'(LATENCY);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = S_DONE;
                    if (!rw_q) begin
                        dout_d = rdata;
                    end
                end
            end
            S_DONE: begin
                // MFA must be seen low here before another request is taken.
                if (!MFA) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

    // A reset during BUSY returns the FSM to IDLE, so access never fires
    // and an aborted write leaves memory untouched.
    always_ff @(posedge CLK) begin
        if (access && rw_q) begin
            case (size_q)
                2'b00: begin
                    mem[addr_q] <= wdata_q[7:0];
                end
                2'b01: begin
                    mem[addr_q] <= wdata_q[15:8];
                    mem[addr1]  <= wdata_q[7:0];
                end
                default: begin
                    mem[addr_q] <= wdata_q[31:24];
                    mem[addr1]  <= wdata_q[23:16];
                    mem[addr2]  <= wdata_q[15:8];
                    mem[addr3]  <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MFC     = (state_q == S_DONE);
    assign Busy    = (state_q != S_IDLE);

endmodule
